xnor_bist_ctrl: RTL and testbench
=================================

# xnor_bist_ctrl

Built-in self-test controller for the 3-input XNOR gate datapath. On a start request it walks all eight input vectors into the gate and compares the gate output against ~(a^b^c). It counts mismatches and records the first failing vector, then reports pass/fail with a done flag. It sits between a host/bench controller and one xnor gate instance, driving the gate inputs directly.

## Interface
- SETTLE_CYCLES, 1, cycles each vector is held before the gate output is sampled; legal range 1..15.
- ERR_W, 4, width of the mismatch counter.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; asynchronous, active-low.
- start  input  1  begin a run; sampled only in IDLE or DONE.
- abort  input  1  synchronous abort; effective only in RUN.
- dut_a, dut_b, dut_c  output  1 each  registered gate inputs; vector v maps as {dut_a,dut_b,dut_c} = v.
- dut_y  input  1  gate output.
- busy  output  1  high while in RUN.
- done  output  1  high in DONE; held until the next start.
- pass  output  1  valid with done; 1 if err_count == 0.
- err_count  output  ERR_W  mismatch count; saturates at 2^ERR_W-1.
- fail_valid  output  1  at least one mismatch seen in the current run.
- fail_vec  output  3  first failing vector; valid when fail_valid is high.

## Operation
- States: IDLE, RUN, DONE. Reset forces IDLE.
- While rst_n is low, all outputs and internal registers are 0: dut_a/b/c, busy, done, pass, err_count, fail_valid, fail_vec, vector index, settle counter.
- IDLE/DONE with start=1:
  - Go to RUN. vec <= 0, dut inputs <= 000, settle counter <= SETTLE_CYCLES-1.
  - Clear err_count, fail_valid, fail_vec, done and pass. busy <= 1.
- RUN, counter != 0: decrement the counter; hold the vector.
- RUN, counter == 0 (sample edge):
  - Compare dut_y with expected = ~(vec[2]^vec[1]^vec[0]).
  - On mismatch: err_count increments, saturating. If fail_valid is 0, set fail_valid=1 and fail_vec=vec.
  - If vec != 7: vec <= vec+1, drive the new vector on the same edge, and reload the counter to SETTLE_CYCLES-1.
  - If vec == 7: go to DONE. busy <= 0, done <= 1, dut inputs <= 000.
  - pass <= 1 only if no mismatch occurred, including the final sample.
- abort=1 in RUN: go to IDLE on that edge.
  - busy <= 0, dut inputs <= 000. done and pass stay 0.
  - err_count, fail_valid and fail_vec hold their partial values.
  - abort outranks a sample edge on the same cycle; that sample is discarded.
- start while in RUN is ignored. abort outside RUN is ignored.
- start and abort together in IDLE/DONE: start wins.
- Reset asserted mid-run: immediate return to IDLE with all outputs 0. No completion is reported.

## Timing
- Let E0 be the edge that samples start.
- Vector v is driven from edge E0+v·S, where S = SETTLE_CYCLES.
- dut_y for vector v is sampled at edge E0+(v+1)·S.
- busy is high from E0 to E0+8S; done rises at E0+8S. Total run: 8·S cycles.
- With S=1, each vector is held exactly one cycle and done rises 8 cycles after start.
- The gate is combinational, so sampling one full cycle after drive is sufficient. Larger S is for registered or slow gate models.
- err_count, fail_vec and pass update on the sample edge itself, with no extra latency.
- Back-to-back run: start held high in DONE restarts on the next edge. done falls on that same edge.

## Test plan
- Correct XNOR gate, S=1, start pulse at cycle 0 → dut vectors 0..7 on cycles 0..7; done=1, pass=1, err_count=0, fail_valid=0 at cycle 8; busy high for exactly 8 cycles.
- Gate replaced by XOR, ERR_W=4 → err_count=8, fail_valid=1, fail_vec=0, pass=0. Repeat with ERR_W=2 → err_count saturates at 3.
- Gate with dut_y stuck at 0 → mismatches on vectors 0,3,5,6, so err_count=4 and fail_vec=0. With stuck at 1 → err_count=4 and fail_vec=1.
- S=3, correct gate → each vector held 3 cycles; done at cycle 24; start pulses during RUN have no effect.
- XOR gate, abort at cycle 4 (S=1) → IDLE at cycle 4 with busy=0, done=0, pass=0, err_count=4, fail_vec=0. Next start gives a full clean run.
- rst_n driven low asynchronously mid-cycle at vector 5 → all outputs 0 immediately. After release, IDLE, and start runs a full 8-vector sequence.

Source files
------------

// File: rtl/xnor_bist_ctrl.sv
// BIST controller for a 3-input XNOR gate: walks all eight input vectors,
// compares the gate output against the expected XNOR, counts mismatches,
// records the first failing vector and reports pass/fail with done.
module xnor_bist_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 1,  // 1..15
  parameter int unsigned ERR_W         = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic             dut_a,
  output logic             dut_b,
  output logic             dut_c,
  input  logic             dut_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             fail_valid,
  output logic [2:0]       fail_vec
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [3:0]       CntReload = 4'(SETTLE_CYCLES - 1);
  localparam logic [ERR_W-1:0] ErrMax    = '1;

  state_e           state_q, state_d;
  logic [2:0]       vec_q, vec_d;
  logic [2:0]       drv_q, drv_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             fv_q, fv_d;
  logic [2:0]       fvec_q, fvec_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             mismatch;

  // Next-state logic: start/abort handling, settle countdown and sampling.
  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    drv_d    = drv_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    fv_d     = fv_q;
    fvec_d   = fvec_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    mismatch = (dut_y != ~(vec_q[2] ^ vec_q[1] ^ vec_q[0]));

    unique case (state_q)
      StIdle, StDone: begin
        // start outranks abort here; abort has no effect outside RUN
        if (start) begin
          state_d = StRun;
          vec_d   = 3'd0;
          drv_d   = 3'd0;
          cnt_d   = CntReload;
          err_d   = '0;
          fv_d    = 1'b0;
          fvec_d  = 3'd0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end
      StRun: begin
        if (abort) begin
          // Partial error results are kept; any pending sample is dropped
          state_d = StIdle;
          busy_d  = 1'b0;
          drv_d   = 3'd0;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (mismatch) begin
            if (err_q != ErrMax) err_d = err_q + 1'b1;
            if (!fv_q) begin
              fv_d   = 1'b1;
              fvec_d = vec_q;
            end
          end
          if (vec_q != 3'd7) begin
            vec_d = vec_q + 3'd1;
            drv_d = vec_q + 3'd1;
            cnt_d = CntReload;
          end else begin
            state_d = StDone;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            drv_d   = 3'd0;
            pass_d  = !fv_q && !mismatch;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and result registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      vec_q   <= 3'd0;
      drv_q   <= 3'd0;
      cnt_q   <= 4'd0;
      err_q   <= '0;
      fv_q    <= 1'b0;
      fvec_q  <= 3'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      drv_q   <= drv_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      fvec_q  <= fvec_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign {dut_a, dut_b, dut_c} = drv_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_valid = fv_q;
  assign fail_vec   = fvec_q;

endmodule

// File: tb/tb_xnor_bist_ctrl.sv
// Directed bench for xnor_bist_ctrl: two instances (S=1/ERR_W=4 and
// S=3/ERR_W=2), each driving a selectable gate model.
module tb_xnor_bist_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic start1 = 1'b0, abort1 = 1'b0;
  logic a1, b1, c1, y1, busy1, done1, pass1, fv1;
  logic [3:0] err1;
  logic [2:0] fvec1;
  int mode1 = 0;

  logic start2 = 1'b0, abort2 = 1'b0;
  logic a2, b2, c2, y2, busy2, done2, pass2, fv2;
  logic [1:0] err2;
  logic [2:0] fvec2;
  int mode2 = 0;

  int total = 0;
  int passed = 0;

  // Gate models: 0 = XNOR, 1 = XOR, 2 = stuck 0, 3 = stuck 1
  function automatic logic gate(input int mode, input logic [2:0] v);
    case (mode)
      0:       return ~(v[2] ^ v[1] ^ v[0]);
      1:       return v[2] ^ v[1] ^ v[0];
      2:       return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  assign y1 = gate(mode1, {a1, b1, c1});
  assign y2 = gate(mode2, {a2, b2, c2});

  always #5 clk = ~clk;

  xnor_bist_ctrl #(.SETTLE_CYCLES(1), .ERR_W(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
    .dut_a(a1), .dut_b(b1), .dut_c(c1), .dut_y(y1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .fail_valid(fv1), .fail_vec(fvec1)
  );

  xnor_bist_ctrl #(.SETTLE_CYCLES(3), .ERR_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2),
    .dut_a(a2), .dut_b(b2), .dut_c(c2), .dut_y(y2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .fail_valid(fv2), .fail_vec(fvec2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero1(input string tag);
    chk({tag, "_vec"}, {29'd0, a1, b1, c1}, 0);
    chk({tag, "_busy"}, busy1, 0);
    chk({tag, "_done"}, done1, 0);
    chk({tag, "_pass"}, pass1, 0);
    chk({tag, "_err"}, err1, 0);
    chk({tag, "_fv"}, fv1, 0);
    chk({tag, "_fvec"}, fvec1, 0);
  endtask

  // Start a run on dut1 (S=1) and check every vector is held one cycle.
  task automatic walk1(input string tag);
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int v = 0; v < 8; v++) begin
      chk({tag, "_vec"}, {29'd0, a1, b1, c1}, v);
      chk({tag, "_busy"}, busy1, 1);
      chk({tag, "_notdone"}, done1, 0);
      tick();
    end
    chk({tag, "_busy_end"}, busy1, 0);
    chk({tag, "_done"}, done1, 1);
    chk({tag, "_vec_end"}, {29'd0, a1, b1, c1}, 0);
  endtask

  // Start a run on dut2 (S=3); an extra start pulse mid-run must be ignored.
  task automatic walk2(input string tag);
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int v = 0; v < 8; v++) begin
      for (int k = 0; k < 3; k++) begin
        chk({tag, "_vec"}, {29'd0, a2, b2, c2}, v);
        chk({tag, "_busy"}, busy2, 1);
        start2 = (v == 2 && k == 1);
        tick();
        start2 = 1'b0;
      end
    end
    chk({tag, "_busy_end"}, busy2, 0);
    chk({tag, "_done"}, done2, 1);
  endtask

  initial begin
    #1;
    chk_zero1("rst");
    chk("rst_busy2", busy2, 0);
    chk("rst_err2", err2, 0);
    #12 rst_n = 1'b1;
    tick();
    chk_zero1("idle");

    // Correct gate
    mode1 = 0;
    walk1("xnor");
    chk("xnor_pass", pass1, 1);
    chk("xnor_err", err1, 0);
    chk("xnor_fv", fv1, 0);

    // abort while in DONE is ignored
    abort1 = 1'b1;
    tick();
    abort1 = 1'b0;
    chk("done_abort_done", done1, 1);
    chk("done_abort_pass", pass1, 1);

    // XOR gate: every vector mismatches
    mode1 = 1;
    walk1("xor");
    chk("xor_err", err1, 8);
    chk("xor_fv", fv1, 1);
    chk("xor_fvec", fvec1, 0);
    chk("xor_pass", pass1, 0);

    // Stuck-at-0: mismatches on 0,3,5,6
    mode1 = 2;
    walk1("st0");
    chk("st0_err", err1, 4);
    chk("st0_fvec", fvec1, 0);
    chk("st0_pass", pass1, 0);

    // Back-to-back restart from DONE with stuck-at-1: mismatches on 1,2,4,7
    mode1 = 3;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk("b2b_done_fall", done1, 0);
    chk("b2b_busy", busy1, 1);
    chk("b2b_err_clr", err1, 0);
    chk("b2b_fv_clr", fv1, 0);
    repeat (8) tick();
    chk("st1_done", done1, 1);
    chk("st1_err", err1, 4);
    chk("st1_fv", fv1, 1);
    chk("st1_fvec", fvec1, 1);
    chk("st1_pass", pass1, 0);

    // XOR with abort raised during cycle 4: vectors 0..3 sampled, vector 4 dropped
    mode1 = 1;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    repeat (4) tick();
    chk("ab_err_pre", err1, 4);
    abort1 = 1'b1;
    tick();
    abort1 = 1'b0;
    chk("ab_busy", busy1, 0);
    chk("ab_done", done1, 0);
    chk("ab_pass", pass1, 0);
    chk("ab_err", err1, 4);
    chk("ab_fv", fv1, 1);
    chk("ab_fvec", fvec1, 0);
    chk("ab_vec", {29'd0, a1, b1, c1}, 0);
    tick();
    chk("ab_idle_busy", busy1, 0);

    // start and abort together in IDLE: start wins, then a clean run
    mode1 = 0;
    start1 = 1'b1;
    abort1 = 1'b1;
    tick();
    start1 = 1'b0;
    abort1 = 1'b0;
    chk("sa_busy", busy1, 1);
    chk("sa_err_clr", err1, 0);
    repeat (8) tick();
    chk("sa_done", done1, 1);
    chk("sa_pass", pass1, 1);
    chk("sa_err", err1, 0);

    // S=3 with correct gate, then XOR saturating a 2-bit counter
    mode2 = 0;
    walk2("s3");
    chk("s3_pass", pass2, 1);
    chk("s3_err", err2, 0);
    mode2 = 1;
    walk2("s3xor");
    chk("sat_err", err2, 3);
    chk("sat_fv", fv2, 1);
    chk("sat_fvec", fvec2, 0);
    chk("sat_pass", pass2, 0);

    // Asynchronous reset mid-run while vector 5 is driven
    mode1 = 0;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    repeat (5) tick();
    chk("pre_rst_vec", {29'd0, a1, b1, c1}, 5);
    #3 rst_n = 1'b0;
    #1;
    chk_zero1("arst");
    chk("arst_done2", done2, 0);
    #2 rst_n = 1'b1;
    tick();
    chk_zero1("post_rst");
    walk1("rerun");
    chk("rerun_pass", pass1, 1);
    chk("rerun_err", err1, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
